// File: rtl/video_scandoubler.sv
// video_scandoubler: line-doubling scan converter (~15.6 kHz in, ~31 kHz out).
// Each input line is captured into one bank of a ping-pong 1 bpp buffer, and the
// previous line is replayed twice at one pixel per clock with regenerated hsync.
// Optional feature: define VIDEO_SCANDOUBLER_SCANLINES_EN to blank the second
// pass of every output line (dark scanlines); sync timing is unaffected.
module video_scandoubler #(
  parameter int unsigned LINE_PIXELS  = 1024,
  parameter int unsigned H_SYNC_WIDTH = 64,
  parameter int unsigned H_BACK_PORCH = 48
) (
  input  logic        clk16_i,
  input  logic        reset_i,
  input  logic        pixel_en_i,
  input  logic        video_i,
  input  logic        h_sync_ni,
  input  logic        v_sync_ni,
  output logic        video_o,
  output logic        h_sync_no,
  output logic        v_sync_no,
  output logic [11:0] line_len_o,
  output logic        overflow_o
);

  localparam int unsigned AW         = $clog2(LINE_PIXELS);
  localparam int unsigned CW         = 12;
  localparam logic [CW-1:0] SYNC_LAST  = CW'(H_SYNC_WIDTH - 1);
  localparam logic [CW-1:0] PORCH_LAST = CW'(H_SYNC_WIDTH + H_BACK_PORCH - 1);
  localparam logic [CW-1:0] CNT_MAX    = {CW{1'b1}};

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    PORCH,
    ACTIVE,
    TAIL
  } state_t;

  // Ping-pong line buffer, bank selected by the MSB of the index.
  logic mem [2*LINE_PIXELS];

  logic          hsync_q;
  logic          ls;
  logic          wr_bank;
  logic [AW:0]   wr_addr;
  logic [AW:0]   rd_len;
  logic [CW-1:0] period_cnt;
  logic [CW-1:0] half;
  logic [CW-1:0] half_last;
  logic          seen_ls;
  logic          valid;

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] out_cnt;
  logic [CW-1:0] cnt_next;
  logic          pass;
  logic          pass_next;
  logic [AW-1:0] rd_addr;
  logic [AW-1:0] rd_addr_next;
  logic          restart;
  logic          rd_en;
  logic [AW:0]   rd_idx;
  logic [AW:0]   wr_idx;
  logic          wr_en;

  // Previous hsync level; sampled during reset too so no false edge follows it.
  always_ff @(posedge clk16_i) begin
    hsync_q <= h_sync_ni;
  end

  // Line start is the first low cycle of the input hsync.
  always_comb begin
    ls        = hsync_q & ~h_sync_ni;
    half_last = half - CW'(1);
    wr_en     = pixel_en_i & ~ls & ~wr_addr[AW];
    wr_idx    = {wr_bank, wr_addr[AW-1:0]};
    rd_idx    = {~wr_bank, rd_addr};
  end

  // Write side: bank swap at line start, pixel capture, sticky overflow.
  // A pixel strobe coinciding with line start is dropped; the line begins empty.
  always_ff @(posedge clk16_i) begin
    if (reset_i) begin
      wr_bank    <= 1'b0;
      wr_addr    <= '0;
      rd_len     <= '0;
      overflow_o <= 1'b0;
    end else if (ls) begin
      wr_bank <= ~wr_bank;
      rd_len  <= wr_addr;
      wr_addr <= '0;
    end else if (pixel_en_i) begin
      if (!wr_addr[AW]) begin
        wr_addr <= wr_addr + (AW+1)'(1);
      end else begin
        overflow_o <= 1'b1;
      end
    end
  end

  // Buffer write port, kept reset-free so it maps onto a RAM.
  always_ff @(posedge clk16_i) begin
    if (wr_en) begin
      mem[wr_idx] <= video_i;
    end
  end

  // Input line period measurement and replay-valid qualification.
  always_ff @(posedge clk16_i) begin
    if (reset_i) begin
      period_cnt <= '0;
      line_len_o <= '0;
      half       <= '0;
      seen_ls    <= 1'b0;
      valid      <= 1'b0;
    end else if (ls) begin
      line_len_o <= period_cnt;
      half       <= {1'b0, period_cnt[CW-1:1]};
      period_cnt <= CW'(1);
      seen_ls    <= 1'b1;
      if (seen_ls) begin
        valid <= 1'b1;
      end
    end else if (period_cnt != CNT_MAX) begin
      period_cnt <= period_cnt + CW'(1);
    end
  end

  // Read FSM state register.
  always_ff @(posedge clk16_i) begin
    if (reset_i) begin
      state   <= IDLE;
      out_cnt <= '0;
      pass    <= 1'b0;
      rd_addr <= '0;
    end else begin
      state   <= state_next;
      out_cnt <= cnt_next;
      pass    <= pass_next;
      rd_addr <= rd_addr_next;
    end
  end

  // Read FSM next state: line start beats the half-period restart.
  always_comb begin
    state_next   = state;
    cnt_next     = out_cnt + CW'(1);
    pass_next    = pass;
    rd_addr_next = rd_addr;
    restart      = 1'b0;
    rd_en        = 1'b0;

    if (ls && (valid || state != IDLE)) begin
      state_next = SYNC;
      cnt_next   = '0;
      pass_next  = 1'b0;
      restart    = 1'b1;
    end else if (state != IDLE && out_cnt == half_last) begin
      cnt_next  = '0;
      if (!pass) begin
        state_next = SYNC;
        pass_next  = 1'b1;
        restart    = 1'b1;
      end else begin
        // Input sync lost: a full second pass ran without a new line start.
        state_next = IDLE;
        pass_next  = 1'b0;
      end
    end else begin
      unique case (state)
        IDLE: begin
          cnt_next = out_cnt;
        end
        SYNC: begin
          if (out_cnt == SYNC_LAST) begin
            state_next = PORCH;
          end
        end
        PORCH: begin
          if (out_cnt == PORCH_LAST) begin
            rd_addr_next = '0;
            state_next   = (rd_len == '0) ? TAIL : ACTIVE;
          end
        end
        ACTIVE: begin
`ifdef VIDEO_SCANDOUBLER_SCANLINES_EN
          rd_en = ~pass;
`else
          rd_en = 1'b1;
`endif
          rd_addr_next = rd_addr + AW'(1);
          if ({1'b0, rd_addr} == rd_len - (AW+1)'(1)) begin
            state_next = TAIL;
          end
        end
        TAIL: begin
          state_next = TAIL;
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  // Registered outputs; the buffer read and video register are the same stage.
  always_ff @(posedge clk16_i) begin
    if (reset_i) begin
      video_o   <= 1'b0;
      h_sync_no <= 1'b1;
      v_sync_no <= 1'b1;
    end else begin
      video_o   <= rd_en ? mem[rd_idx] : 1'b0;
      h_sync_no <= (state_next != SYNC);
      if (restart) begin
        v_sync_no <= v_sync_ni;
      end
    end
  end

endmodule

// File: tb/tb_video_scandoubler.sv
// Directed bench for video_scandoubler: reset, steady-state doubling, vsync
// alignment, overflow and lost-sync recovery, using default parameters.
module tb_video_scandoubler;

  logic        clk16_i;
  logic        reset_i;
  logic        pixel_en_i;
  logic        video_i;
  logic        h_sync_ni;
  logic        v_sync_ni;
  logic        video_o;
  logic        h_sync_no;
  logic        v_sync_no;
  logic [11:0] line_len_o;
  logic        overflow_o;

  int compared;
  int mismatched;

  bit cap_v  [4096];
  bit cap_hs [4096];
  bit cap_vs [4096];

  video_scandoubler dut (
    .clk16_i    (clk16_i),
    .reset_i    (reset_i),
    .pixel_en_i (pixel_en_i),
    .video_i    (video_i),
    .h_sync_ni  (h_sync_ni),
    .v_sync_ni  (v_sync_ni),
    .video_o    (video_o),
    .h_sync_no  (h_sync_no),
    .v_sync_no  (v_sync_no),
    .line_len_o (line_len_o),
    .overflow_o (overflow_o)
  );

  initial clk16_i = 1'b0;
  always #5 clk16_i = ~clk16_i;

  // Pixel patterns: 0 = 1010..., 1 = all ones, 2 = 100100...
  function automatic bit pat_bit(input int p, input int i);
    if (p == 0) return (i % 2) == 0;
    if (p == 1) return 1'b1;
    return (i % 3) == 0;
  endfunction

  // Expected hsync at sample k of a line (k=0 is the input line-start cycle).
  function automatic bit exp_hs(input int k, input int h);
    return !((k >= 1 && k <= 64) || (k >= h + 1 && k <= h + 64));
  endfunction

  // Expected video at sample k when replaying n pixels of pattern p with half period h.
  function automatic bit exp_vid(input int k, input int h, input int n, input int p);
    if (k >= 114 && k < 114 + n) return pat_bit(p, k - 114);
`ifndef VIDEO_SCANDOUBLER_SCANLINES_EN
    if (k >= h + 114 && k < h + 114 + n) return pat_bit(p, k - h - 114);
`endif
    return 1'b0;
  endfunction

  // Drive one input line of 'period' cycles and capture the outputs per cycle.
  task automatic drive_line(input int period, input bit hs_on, input int npix,
                            input int pat, input int vs_at, input bit vs_val);
    for (int k = 0; k < period; k++) begin
      @(posedge clk16_i);
      #1;
      h_sync_ni  = !(hs_on && k < 32);
      if (k == vs_at) v_sync_ni = vs_val;
      pixel_en_i = (k >= 40) && (((k - 40) % 2) == 0) && (((k - 40) / 2) < npix);
      video_i    = pixel_en_i ? pat_bit(pat, (k - 40) / 2) : 1'b0;
      @(negedge clk16_i);
      cap_v[k]  = video_o;
      cap_hs[k] = h_sync_no;
      cap_vs[k] = v_sync_no;
    end
  endtask

  task automatic test_reset;
    int lows;
    int ones;
    @(posedge clk16_i);
    #1 reset_i = 1'b1;
    repeat (2) @(posedge clk16_i);
    #1 reset_i = 1'b0;
    @(negedge clk16_i);
    compared++; if (video_o !== 1'b0) begin mismatched++; $display("FAIL reset_video: got %b want 0", video_o); end
    compared++; if (h_sync_no !== 1'b1) begin mismatched++; $display("FAIL reset_hsync: got %b want 1", h_sync_no); end
    compared++; if (v_sync_no !== 1'b1) begin mismatched++; $display("FAIL reset_vsync: got %b want 1", v_sync_no); end
    compared++; if (overflow_o !== 1'b0) begin mismatched++; $display("FAIL reset_overflow: got %b want 0", overflow_o); end
    compared++; if (line_len_o !== 12'd0) begin mismatched++; $display("FAIL reset_line_len: got %0d want 0", line_len_o); end
    for (int l = 1; l <= 2; l++) begin
      drive_line(1024, 1'b1, 320, 0, -1, 1'b1);
      lows = 0; ones = 0;
      for (int k = 0; k < 1024; k++) begin
        if (!cap_hs[k]) lows++;
        if (cap_v[k]) ones++;
      end
      compared++; if (lows !== 0) begin mismatched++; $display("FAIL no_sync_line%0d: got %0d low cycles want 0", l, lows); end
      compared++; if (ones !== 0) begin mismatched++; $display("FAIL no_video_line%0d: got %0d lit cycles want 0", l, ones); end
    end
  endtask

  task automatic test_steady;
    int errs;
    int npat [4] = '{0, 1, 2, 0};
    int nlen [4] = '{320, 320, 200, 320};
    int prev_p;
    int prev_n;
    prev_p = 0; prev_n = 320;
    for (int l = 0; l < 4; l++) begin
      drive_line(1024, 1'b1, nlen[l], npat[l], -1, 1'b1);
      compared++; if (line_len_o !== 12'd1024) begin mismatched++; $display("FAIL line_len_%0d: got %0d want 1024", l, line_len_o); end
      errs = 0;
      for (int k = 0; k < 1024; k++) if (cap_hs[k] !== exp_hs(k, 512)) errs++;
      compared++; if (errs !== 0) begin mismatched++; $display("FAIL hsync_shape_%0d: got %0d bad cycles want 0", l, errs); end
      errs = 0;
      for (int k = 0; k < 1024; k++) if (cap_v[k] !== exp_vid(k, 512, prev_n, prev_p)) errs++;
      compared++; if (errs !== 0) begin mismatched++; $display("FAIL video_replay_%0d: got %0d bad cycles want 0", l, errs); end
      if (l == 0) begin
        compared++; if (cap_hs[1] !== 1'b0 || cap_hs[64] !== 1'b0 || cap_hs[65] !== 1'b1)
          begin mismatched++; $display("FAIL hsync_pass0_edges: got %b%b%b want 001", cap_hs[1], cap_hs[64], cap_hs[65]); end
        compared++; if (cap_hs[512] !== 1'b1 || cap_hs[513] !== 1'b0 || cap_hs[577] !== 1'b1)
          begin mismatched++; $display("FAIL hsync_pass1_edges: got %b%b%b want 101", cap_hs[512], cap_hs[513], cap_hs[577]); end
        compared++; if (cap_v[113] !== 1'b0 || cap_v[114] !== 1'b1 || cap_v[115] !== 1'b0)
          begin mismatched++; $display("FAIL first_pixels: got %b%b%b want 010", cap_v[113], cap_v[114], cap_v[115]); end
      end
      prev_p = npat[l]; prev_n = nlen[l];
    end
  endtask

  task automatic test_vsync;
    drive_line(1024, 1'b1, 320, 0, 300, 1'b0);
    compared++; if (cap_vs[400] !== 1'b1 || cap_vs[512] !== 1'b1)
      begin mismatched++; $display("FAIL vsync_hold: got %b%b want 11", cap_vs[400], cap_vs[512]); end
    compared++; if (cap_vs[513] !== 1'b0) begin mismatched++; $display("FAIL vsync_fall: got %b want 0", cap_vs[513]); end
    drive_line(1024, 1'b1, 320, 0, 0, 1'b1);
    compared++; if (cap_vs[0] !== 1'b0 || cap_vs[1] !== 1'b1)
      begin mismatched++; $display("FAIL vsync_rise: got %b%b want 01", cap_vs[0], cap_vs[1]); end
  endtask

  task automatic test_overflow;
    int errs;
    int ones;
    compared++; if (overflow_o !== 1'b0) begin mismatched++; $display("FAIL overflow_early: got %b want 0", overflow_o); end
    drive_line(2400, 1'b1, 1100, 1, -1, 1'b1);
    compared++; if (overflow_o !== 1'b1) begin mismatched++; $display("FAIL overflow_set: got %b want 1", overflow_o); end
    drive_line(2400, 1'b1, 100, 0, -1, 1'b1);
    compared++; if (overflow_o !== 1'b1) begin mismatched++; $display("FAIL overflow_sticky: got %b want 1", overflow_o); end
    compared++; if (line_len_o !== 12'd2400) begin mismatched++; $display("FAIL line_len_2400: got %0d want 2400", line_len_o); end
    ones = 0;
    for (int k = 1; k <= 1200; k++) if (cap_v[k]) ones++;
    compared++; if (ones !== 1024) begin mismatched++; $display("FAIL overflow_replay_len: got %0d pixels want 1024", ones); end
    errs = 0;
    for (int k = 0; k < 2400; k++) begin
      if (cap_v[k] !== exp_vid(k, 1200, 1024, 1)) errs++;
      if (cap_hs[k] !== exp_hs(k, 1200)) errs++;
    end
    compared++; if (errs !== 0) begin mismatched++; $display("FAIL overflow_replay: got %0d bad cycles want 0", errs); end
  endtask

  task automatic test_lost_sync;
    int lows;
    int ones;
    int errs;
    drive_line(1000, 1'b0, 0, 0, -1, 1'b1);
    lows = 0; ones = 0;
    for (int k = 0; k < 1000; k++) begin
      if (!cap_hs[k]) lows++;
      if (cap_v[k]) ones++;
    end
    compared++; if (lows !== 0) begin mismatched++; $display("FAIL lost_sync_hsync: got %0d low cycles want 0", lows); end
    compared++; if (ones !== 0) begin mismatched++; $display("FAIL lost_sync_video: got %0d lit cycles want 0", ones); end
    drive_line(1024, 1'b1, 0, 0, -1, 1'b1);
    compared++; if (line_len_o !== 12'd3400) begin mismatched++; $display("FAIL line_len_3400: got %0d want 3400", line_len_o); end
    compared++; if (cap_hs[0] !== 1'b1 || cap_hs[1] !== 1'b0)
      begin mismatched++; $display("FAIL resync_hsync: got %b%b want 10", cap_hs[0], cap_hs[1]); end
    errs = 0;
    for (int k = 0; k < 1024; k++) begin
      if (cap_v[k] !== exp_vid(k, 1700, 100, 0)) errs++;
      if (cap_hs[k] !== exp_hs(k, 1700)) errs++;
    end
    compared++; if (errs !== 0) begin mismatched++; $display("FAIL resync_replay: got %0d bad cycles want 0", errs); end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    reset_i    = 1'b1;
    pixel_en_i = 1'b0;
    video_i    = 1'b0;
    h_sync_ni  = 1'b1;
    v_sync_ni  = 1'b1;
    test_reset();
    test_steady();
    test_vsync();
    test_overflow();
    test_lost_sync();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/video_scandoubler.md
# video_scandoubler

Line-doubling scan converter downstream of the `video` block. It captures each PET video line, which arrives as 1 bpp pixels on a pixel-enable strobe in the `clk16_i` domain, into a ping-pong line buffer. It then replays the previous line twice at one pixel per `clk16_i` cycle, with regenerated horizontal sync at twice the input line rate. This converts ~15.6 kHz PET timing to ~31 kHz timing for VGA-class monitors.

## Interface
Parameters:
- `LINE_PIXELS`, 1024: buffer depth per bank, in pixels (power of two).
- `H_SYNC_WIDTH`, 64: output hsync low time, in `clk16_i` cycles.
- `H_BACK_PORCH`, 48: cycles from the end of hsync to the first replayed pixel.

Ports:
- `clk16_i`  in  1  16 MHz system clock; the only clock.
- `reset_i`  in  1  Reset: synchronous, active-high.
- `pixel_en_i`  in  1  Input pixel strobe; never asserted on two consecutive cycles.
- `video_i`  in  1  Input pixel, sampled when `pixel_en_i`=1.
- `h_sync_ni`  in  1  Input hsync, active-low.
- `v_sync_ni`  in  1  Input vsync, active-low.
- `video_o`  out  1  Output pixel, registered.
- `h_sync_no`  out  1  Output hsync, active-low, registered.
- `v_sync_no`  out  1  Output vsync, active-low, registered.
- `line_len_o`  out  12  Last measured input line period in cycles; saturates at 4095.
- `overflow_o`  out  1  Sticky flag: an input line exceeded `LINE_PIXELS`.

## Operation
- **Edge detect:** `h_sync_ni` is registered. A "line start" (LS) is the cycle on which a 1→0 transition is detected.
- **Write side:**
  - On LS: toggle `wr_bank`; latch `wr_addr` into `rd_len`; clear `wr_addr`.
  - On `pixel_en_i`: if `wr_addr < LINE_PIXELS`, write `video_i` to `buf[wr_bank][wr_addr]` and increment `wr_addr`.
  - Otherwise drop the pixel and set `overflow_o`.
- **Period measurement:**
  - `period_cnt` increments every cycle and saturates at 4095.
  - On LS: `line_len_o` ← `period_cnt`, `half` ← `period_cnt >> 1`, `period_cnt` ← 1.
  - `valid` is set on the second LS after reset.
- **Read FSM:** states IDLE, SYNC, PORCH, ACTIVE, TAIL.
  - `out_cnt` counts cycles within the current output pass. `pass` ∈ {0,1}.
  - IDLE → SYNC on LS when `valid`: `pass`=0, `out_cnt`=0.
  - From any non-IDLE state: on LS, restart pass 0. When `out_cnt == half-1` and `pass`=0, restart as pass 1. LS has priority if both occur on the same cycle.
  - SYNC: `h_sync_no`=0 for `H_SYNC_WIDTH` cycles, then PORCH.
  - PORCH: lasts `H_BACK_PORCH` cycles, then ACTIVE with `rd_addr`=0.
  - ACTIVE: read `buf[!wr_bank][rd_addr]` and increment `rd_addr` every cycle. Go to TAIL when `rd_addr == rd_len-1`, or immediately if `rd_len`=0 (blank line).
  - TAIL: `video_o`=0, hold until the next pass restart.
  - If `out_cnt` reaches `half-1` in pass 1 (input sync lost), go to IDLE. Outputs stay idle until the next LS.
- **Vertical sync:** `v_sync_no` ← `v_sync_ni`, sampled only at pass restarts, so vsync edges align to output line boundaries.
- **Blanking:** `video_o`=0 in all states except ACTIVE.
- **Reset state:**
  - Outputs: `video_o`=0, `h_sync_no`=1, `v_sync_no`=1, `line_len_o`=0, `overflow_o`=0.
  - Internal: FSM IDLE, `valid`=0, `rd_len`=0, `wr_bank`=0.
  - Buffer contents are not cleared.
  - Reset mid-line discards the line in progress.

## Timing
- **Sync latency:** `h_sync_no` falls 1 cycle after the cycle in which LS (or the half-period restart) is detected.
- **Pixel latency:** pixel *i* of the previous input line appears on `video_o` at `out_cnt = H_SYNC_WIDTH + H_BACK_PORCH + 1 + i`. This includes one cycle of registered RAM read.
- **Line latency:** a line captured during input line N is output twice during input line N+1.
- **Active-width limit:** the replayed active width must fit in `half - H_SYNC_WIDTH - H_BACK_PORCH - 1` cycles. Excess pixels are truncated by the pass restart.

## Configuration
- Macro: `VIDEO_SCANDOUBLER_SCANLINES_EN`.
- Defined: `video_o` is forced to 0 during pass 1. This gives a dark-scanline effect; sync is unchanged.
- Undefined: pass 0 and pass 1 output identical pixels.

## Test plan
- **Reset:** assert `reset_i` for 2 cycles → `video_o`=0, `h_sync_no`=1, `v_sync_no`=1, `overflow_o`=0. No `h_sync_no` pulse until 2 LS have occurred.
- **Steady state:** input period 1024, 320 pixels of 1010… with `pixel_en_i` every 2nd cycle →
  - `line_len_o`=1024.
  - `h_sync_no` low for 64 cycles starting 1 cycle after LS and 1 cycle after `out_cnt`=511.
  - Pattern replayed at 1 pixel/cycle starting at `out_cnt`=113, twice per input line.
- **Overflow:** 1100 `pixel_en_i` in one line → `overflow_o`=1 and stays 1. The next output lines replay exactly 1024 pixels.
- **Scanlines:** with `VIDEO_SCANDOUBLER_SCANLINES_EN` defined and an all-1 line → `video_o`=1 in pass 0 and `video_o`=0 in pass 1.
- **Lost sync:** stop input hsync after a valid line → pass 1 completes, then FSM goes IDLE with `h_sync_no`=1. The next LS restarts pass 0.
- **Vertical sync alignment:** drop `v_sync_ni` mid-pass → `v_sync_no` falls exactly 1 cycle after the next pass restart.
